pc_branch_ctrl: RTL
===================

Name: pc_branch_ctrl

Overview:
Program counter and branch-resolution stage sitting directly downstream of the Z flag register; consumes its registered zero flag.
- Resolves unconditional, branch-if-zero and branch-if-not-zero requests.
- Redirects the PC and holds a flush window so the fetch path discards wrong-path instructions.
- Single clock domain, one register stage from request to new PC.

Parameters:
PC_W, 8, program counter width in bits
RESET_PC, 0, PC value loaded by clear
FLUSH_CYC, 1, cycles flush stays asserted after a taken branch; legal range 1..15

Ports:
clk  input  1  clock; all state updates on the rising edge
clear  input  1  reset, synchronous, active-high
en  input  1  advance enable from fetch; low = hold PC
z_flag  input  1  registered zero flag from the Z flag register output (out1)
br_valid  input  1  branch request valid this cycle
br_type  input  2  00 JMP, 01 BZ (taken if z_flag=1), 10 BNZ (taken if z_flag=0), 11 reserved (never taken)
br_target  input  PC_W  branch destination
pc  output  PC_W  current program counter (registered)
flush  output  1  discard in-flight fetch (registered)
busy  output  1  high while in FLUSH state; upstream must not rely on br_valid being accepted

Behaviour:
- Interface: one clock, clk; reset is clear, synchronous and active-high, sampled only on the rising edge of clk.
- clear has priority over every other input.
- Reset values: pc=RESET_PC, flush=0, busy=0, state=RUN, flush counter=0.
- States: RUN, FLUSH.
- busy is decoded directly from state: 1 exactly when state=FLUSH.
- RUN, en=0: pc holds; br_valid ignored (no branch is evaluated or lost-tracked).
- RUN, en=1, taken (br_valid=1 and type/z_flag condition true):
  - next edge: pc<=br_target, flush<=1, counter<=FLUSH_CYC-1, state<=FLUSH.
  - Latency from request to redirected pc: 1 cycle.
- RUN, en=1, not taken (br_valid=0, condition false, or type 11): pc<=pc+1, flush<=0.
- PC increment is modulo 2^PC_W; all-ones wraps to 0 with no flag.
- z_flag is sampled in the same cycle as br_valid. A Z-register write on that same edge is not visible; the branch uses the pre-edge value.
- FLUSH, every cycle regardless of en:
  - pc holds at the target; flush=1; br_valid ignored and dropped.
  - If counter=0: state<=RUN, flush<=0. Otherwise counter decrements.
  - flush is therefore high for exactly FLUSH_CYC consecutive cycles.
- First cycle back in RUN: normal rules apply (pc+1 if en, and a new branch may be taken back-to-back).
- clear mid-FLUSH: next cycle pc=RESET_PC, flush=0, busy=0, state=RUN; the pending redirect is abandoned.
- br_target wider values: none; exactly PC_W bits, used unmodified.

Optional Feature:
Macro PC_BRANCH_STATS_EN.
- Defined:
  - Adds output port taken_cnt, 8 bits.
  - Increments on every cycle a branch is taken; saturates at 255.
  - Reset to 0 by clear.
  - Not-taken, ignored and type-11 requests do not count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset/sequential fetch: clear=1 for 2 cycles -> pc=0, flush=0, busy=0. Then clear=0, en=1 for 4 cycles -> pc 1,2,3,4. With en=0, pc holds.
- BZ taken: pc=5, en=1, br_valid=1, br_type=01, z_flag=1, br_target=0x40 -> next cycle pc=0x40, flush=1, busy=1. Cycle after: flush=0, then pc=0x41.
- BZ not taken / BNZ taken:
  - BZ with z_flag=0 at pc=5 -> pc=6, flush stays 0.
  - BNZ with z_flag=0, target 0x20 -> pc=0x20, flush=1.
- FLUSH_CYC=3: JMP to 0x10, then br_valid=1 BNZ target 0x80 driven during flush -> flush high exactly 3 cycles, pc stays 0x10, request ignored, then pc=0x11.
- Wrap/reserved:
  - pc=0xFF, en=1 -> pc=0x00.
  - br_type=11 with target 0x33 -> pc+1, no flush.
- Clear mid-flush: FLUSH_CYC=3, clear=1 in the second flush cycle -> next cycle pc=0, flush=0, busy=0. With PC_BRANCH_STATS_EN, taken_cnt=0; 300 taken JMPs -> taken_cnt=255.

Source files
------------

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter with branch resolution and flush window
//
// Purpose: advances the PC on fetch enable. It resolves JMP/BZ/BNZ requests against
// the registered zero flag. On a taken branch it redirects the PC and holds a flush
// window, so the fetch path can discard wrong-path instructions.
//
// Optional feature macro: PC_BRANCH_STATS_EN (adds the taken_cnt output).
//
// Ports:
//   clk        in   clock; every state update happens on the rising edge
//   clear      in   synchronous active-high reset; has priority over all other inputs
//   en         in   advance enable from fetch; low holds the PC while running
//   z_flag     in   registered zero flag; its pre-edge value is used
//   br_valid   in   branch request valid this cycle
//   br_type    in   00 JMP, 01 BZ, 10 BNZ, 11 reserved (never taken)
//   br_target  in   branch destination, PC_W bits, used unmodified
//   pc         out  current program counter (registered)
//   flush      out  discard in-flight fetch (registered)
//   busy       out  high while in the FLUSH state
//   taken_cnt  out  saturating count of taken branches (PC_BRANCH_STATS_EN only)

module pc_branch_ctrl #(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              FLUSH_CYC = 1
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            en,
    input  logic            z_flag,
    input  logic            br_valid,
    input  logic [1:0]      br_type,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic            flush,
`ifdef PC_BRANCH_STATS_EN
    output logic            busy,
    output logic [7:0]      taken_cnt
`else
    output logic            busy
`endif
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // The counter is loaded with FLUSH_CYC-1 because the cycle that sees
    // the counter at zero is itself the last flush cycle.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            cond_met;
    logic            taken;

    always_comb begin
        cond_met = 1'b0;
        case (br_type)
            2'b00:   cond_met = 1'b1;
            2'b01:   cond_met = z_flag;
            2'b10:   cond_met = ~z_flag;
            default: cond_met = 1'b0;
        endcase
    end

    // A request can only be taken while running and advancing.
    // Requests that arrive during FLUSH are dropped, not queued.
    assign taken = (state_q == ST_RUN) && en && br_valid && cond_met;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                flush_d = 1'b0;
                if (en) begin
                    if (taken) begin
                        pc_d    = br_target;
                        flush_d = 1'b1;
                        cnt_d   = FLUSH_INIT;
                        state_d = ST_FLUSH;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc    = pc_q;
    assign flush = flush_q;
    assign busy  = (state_q == ST_FLUSH);

`ifdef PC_BRANCH_STATS_EN
    logic [7:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (taken && (taken_cnt_q != 8'hFF)) begin
            taken_cnt_d = taken_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            taken_cnt_q <= 8'd0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
`endif

endmodule
